vec_scoreboard: RTL and testbench

VEC_SCOREBOARD -- requirements
Module: vec_scoreboard

---
 rtl/vec_sb_pkg.sv | 32 +++
 rtl/vec_scoreboard_if.sv | 45 ++++
 rtl/vec_scoreboard_entry.sv | 41 ++++
 rtl/vec_scoreboard.sv | 105 ++++++++++
 tb/tb_vec_scoreboard.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/vec_sb_pkg.sv
// ============================================================================
// Module  : vec_sb_pkg
// Brief   : Shared types, defaults and forward-select helper for vec_scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none

package vec_sb_pkg;

   localparam int c_nreg_default   = 16;
   localparam int c_maxlat_default = 4;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   // A producer two cycles out sits in memory, one cycle out in writeback.
   function automatic fwd_sel_e fwd_select(input logic used, input int unsigned cnt);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (used && cnt == 2)
         sel = FWD_MEM;
      else if (used && cnt == 1)
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vec_scoreboard_if.sv
// ============================================================================
// Module  : vec_scoreboard_if
// Brief   : Decode-side request and hazard/forward response bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface vec_scoreboard_if #(
   parameter int NREG   = 16,
   parameter int MAXLAT = 4
) ();
   localparam int RW = $clog2(NREG);
   localparam int LW = $clog2(MAXLAT + 1);

   logic          issue_d;
   logic [RW-1:0] ra1_d;
   logic [RW-1:0] ra2_d;
   logic          use_a_d;
   logic          use_b_d;
   logic [RW-1:0] wa3_d;
   logic          reg_write_d;
   logic          mem_to_reg_d;
   logic [LW-1:0] lat_d;
   logic          flush_d;
   logic          stall_f;
   logic          stall_d;
   logic          flush_e;
   logic [1:0]    forward_ae;
   logic [1:0]    forward_be;
   logic          busy;

   modport master (
      output issue_d, ra1_d, ra2_d, use_a_d, use_b_d, wa3_d, reg_write_d,
             mem_to_reg_d, lat_d, flush_d,
      input  stall_f, stall_d, flush_e, forward_ae, forward_be, busy
   );

   modport slave (
      input  issue_d, ra1_d, ra2_d, use_a_d, use_b_d, wa3_d, reg_write_d,
             mem_to_reg_d, lat_d, flush_d,
      output stall_f, stall_d, flush_e, forward_ae, forward_be, busy
   );
endinterface

`default_nettype wire

// File: rtl/vec_scoreboard_entry.sv
// ============================================================================
// Module  : sb_entry
// Brief   : Per-register pending-write countdown and load-producer flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module sb_entry #(
   parameter int LW = 3
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   input  wire logic          i_load,
   input  wire logic [LW-1:0] i_lat,
   input  wire logic          i_ld,
   output logic      [LW-1:0] o_cnt,
   output logic               o_ld
);

   logic [LW-1:0] r_cnt;
   logic          r_ld;

   // A new producer overrides the running countdown of the old one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_ld  <= 1'b0;
      end else if (i_load) begin
         r_cnt <= i_lat;
         r_ld  <= i_ld;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - LW'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_ld  = r_ld;

endmodule

`default_nettype wire

// File: rtl/vec_scoreboard.sv
// ============================================================================
// Module  : vec_scoreboard
// Brief   : Latency-counting register scoreboard with stall and forward select
// Revision: 1.0
// ============================================================================
`default_nettype none

module vec_scoreboard
   import vec_sb_pkg::*;
#(
   parameter int NREG   = c_nreg_default,
   parameter int MAXLAT = c_maxlat_default
) (
   input wire logic        clk,
   input wire logic        rst_n,
   vec_scoreboard_if.slave sb
);

   localparam int RW = $clog2(NREG);
   localparam int LW = $clog2(MAXLAT + 1);

   logic [LW-1:0]   w_cnt [NREG];
   logic [NREG-1:0] w_ld;
   logic [NREG-1:0] w_pend;
   logic [NREG-1:0] w_load;
   logic [LW-1:0]   w_lat_sat;
   logic [LW-1:0]   w_cnt_a;
   logic [LW-1:0]   w_cnt_b;
   logic [LW-1:0]   w_cnt_w;
   logic            w_haz_a;
   logic            w_haz_b;
   logic            w_waw;
   logic            w_stall;
   logic            w_fire;
   fwd_sel_e        w_sel_a;
   fwd_sel_e        w_sel_b;
   fwd_sel_e        r_fwd_a;
   fwd_sel_e        r_fwd_b;

   // All checks look at pre-update counts, so a self-reading writer sees the old producer.
   always_comb begin
      w_lat_sat = sb.lat_d;
      if (sb.lat_d == '0)
         w_lat_sat = LW'(1);
      else if (sb.lat_d > LW'(MAXLAT))
         w_lat_sat = LW'(MAXLAT);

      w_cnt_a = w_cnt[sb.ra1_d];
      w_cnt_b = w_cnt[sb.ra2_d];
      w_cnt_w = w_cnt[sb.wa3_d];

      w_haz_a = sb.use_a_d &&
                ((w_cnt_a > LW'(2)) || ((w_cnt_a == LW'(2)) && w_ld[sb.ra1_d]));
      w_haz_b = sb.use_b_d &&
                ((w_cnt_b > LW'(2)) || ((w_cnt_b == LW'(2)) && w_ld[sb.ra2_d]));
      w_waw   = sb.reg_write_d && (w_cnt_w != '0) && (w_lat_sat <= w_cnt_w);

      w_stall = sb.issue_d && !sb.flush_d && (w_haz_a || w_haz_b || w_waw);
      w_fire  = sb.issue_d && !sb.flush_d && !w_stall;

      w_sel_a = fwd_select(sb.use_a_d, 32'(w_cnt_a));
      w_sel_b = fwd_select(sb.use_b_d, 32'(w_cnt_b));
   end

   for (genvar i = 0; i < NREG; i++) begin : g_entry
      assign w_load[i] = w_fire && sb.reg_write_d && (sb.wa3_d == RW'(i));
      assign w_pend[i] = (w_cnt[i] != '0);

      sb_entry #(
         .LW (LW)
      ) u_entry (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_load (w_load[i]),
         .i_lat  (w_lat_sat),
         .i_ld   (sb.mem_to_reg_d),
         .o_cnt  (w_cnt[i]),
         .o_ld   (w_ld[i])
      );
   end

   // Anything other than a firing issue becomes an execute bubble reading the RF.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd_a <= FWD_RF;
         r_fwd_b <= FWD_RF;
      end else if (w_fire) begin
         r_fwd_a <= w_sel_a;
         r_fwd_b <= w_sel_b;
      end else begin
         r_fwd_a <= FWD_RF;
         r_fwd_b <= FWD_RF;
      end
   end

   assign sb.stall_f    = w_stall;
   assign sb.stall_d    = w_stall;
   assign sb.flush_e    = w_stall || sb.flush_d;
   assign sb.forward_ae = r_fwd_a;
   assign sb.forward_be = r_fwd_b;
   assign sb.busy       = |w_pend;

endmodule

`default_nettype wire

// File: tb/tb_vec_scoreboard.sv
// ============================================================================
// Module  : tb_vec_scoreboard
// Brief   : Directed-vector bench for vec_scoreboard (default and 32x8 builds)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vec_scoreboard;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   vec_scoreboard_if #(.NREG(16), .MAXLAT(4)) sb0 ();
   vec_scoreboard_if #(.NREG(32), .MAXLAT(8)) sb1 ();

   vec_scoreboard #(.NREG(16), .MAXLAT(4)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb0)
   );

   vec_scoreboard #(.NREG(32), .MAXLAT(8)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set0(input logic iss, input logic [3:0] ra1, input logic ua,
                       input logic [3:0] ra2, input logic ub, input logic [3:0] wa,
                       input logic rw, input logic mem, input logic [2:0] lat,
                       input logic fl);
      sb0.issue_d      = iss;
      sb0.ra1_d        = ra1;
      sb0.use_a_d      = ua;
      sb0.ra2_d        = ra2;
      sb0.use_b_d      = ub;
      sb0.wa3_d        = wa;
      sb0.reg_write_d  = rw;
      sb0.mem_to_reg_d = mem;
      sb0.lat_d        = lat;
      sb0.flush_d      = fl;
   endtask

   task automatic set1(input logic iss, input logic [4:0] ra1, input logic ua,
                       input logic [4:0] ra2, input logic ub, input logic [4:0] wa,
                       input logic rw, input logic [3:0] lat);
      sb1.issue_d      = iss;
      sb1.ra1_d        = ra1;
      sb1.use_a_d      = ua;
      sb1.ra2_d        = ra2;
      sb1.use_b_d      = ub;
      sb1.wa3_d        = wa;
      sb1.reg_write_d  = rw;
      sb1.mem_to_reg_d = 1'b0;
      sb1.lat_d        = lat;
      sb1.flush_d      = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      set0(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      set1(0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      chk("rst busy", sb0.busy, 0);
      chk("rst stall", sb0.stall_d, 0);
      chk("rst flush_e", sb0.flush_e, 0);
      chk("rst fwd_a", sb0.forward_ae, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU producer r3, latency 3, consumed once it is two cycles out
      set0(1, 0, 0, 0, 0, 3, 1, 0, 3, 0);
      #1 chk("alu issue stall", sb0.stall_d, 0);
      tick();
      chk("alu busy", sb0.busy, 1);
      set0(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      set0(1, 3, 1, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("alu read stall", sb0.stall_d, 0);
      tick();
      chk("alu fwd_a mem", sb0.forward_ae, 2'b10);
      set0(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      chk("alu drained", sb0.busy, 0);

      // Load producer r5, latency 2, read immediately
      set0(1, 0, 0, 0, 0, 5, 1, 1, 2, 0);
      tick();
      set0(1, 5, 1, 5, 0, 0, 0, 0, 1, 0);
      #1 chk("load stall_f", sb0.stall_f, 1);
      chk("load flush_e", sb0.flush_e, 1);
      tick();
      chk("load bubble fwd_a", sb0.forward_ae, 0);
      chk("load retry stall", sb0.stall_d, 0);
      tick();
      chk("load fwd_a wb", sb0.forward_ae, 2'b01);
      chk("load fwd_b unused", sb0.forward_be, 0);
      chk("load drained", sb0.busy, 0);

      // WAW on r7: latency 4 then latency 2
      set0(1, 0, 0, 0, 0, 7, 1, 0, 4, 0);
      tick();
      set0(1, 0, 0, 0, 0, 7, 1, 0, 2, 0);
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("waw stall %0d", i), sb0.stall_d, 1);
         tick();
      end
      #1 chk("waw release", sb0.stall_d, 0);
      tick();
      set0(1, 0, 0, 0, 0, 7, 0, 0, 1, 0);
      #1 chk("no waw rw0", sb0.stall_d, 0);
      tick();
      chk("waw reissue busy", sb0.busy, 1);
      set0(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      chk("waw drained", sb0.busy, 0);

      // Flushed issue leaves no trace
      set0(1, 0, 0, 0, 0, 2, 1, 0, 4, 1);
      #1 chk("flush flush_e", sb0.flush_e, 1);
      chk("flush stall", sb0.stall_d, 0);
      tick();
      chk("flush busy", sb0.busy, 0);
      chk("flush fwd_a", sb0.forward_ae, 0);

      // Latency saturation: 0 -> 1, 7 -> 4
      set0(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
      tick();
      chk("lat0 busy", sb0.busy, 1);
      set0(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      chk("lat0 drained", sb0.busy, 0);
      set0(1, 0, 0, 0, 0, 4, 1, 0, 7, 0);
      tick();
      set0(1, 4, 1, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 2; i++) begin
         #1 chk($sformatf("sat stall %0d", i), sb0.stall_d, 1);
         tick();
      end
      #1 chk("sat release", sb0.stall_d, 0);
      tick();
      chk("sat fwd_a mem", sb0.forward_ae, 2'b10);
      set0(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

      // Reset while a write is pending
      set0(1, 0, 0, 0, 0, 1, 1, 0, 4, 0);
      tick();
      set0(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      rst_n = 1'b0;
      #1 chk("midrst busy", sb0.busy, 0);
      chk("midrst fwd_a", sb0.forward_ae, 0);
      tick();
      rst_n = 1'b1;
      set0(1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      #1 chk("postrst stall", sb0.stall_d, 0);
      tick();
      chk("postrst fwd_a", sb0.forward_ae, 0);
      set0(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

      // 32x8 build: r31 latency 8, read on both operands every cycle
      set1(1, 0, 0, 0, 0, 31, 1, 8);
      tick();
      set1(1, 31, 1, 31, 1, 0, 0, 1);
      for (int i = 0; i < 6; i++) begin
         #1 chk($sformatf("big stall %0d", i), sb1.stall_d, 1);
         tick();
      end
      #1 chk("big release", sb1.stall_d, 0);
      tick();
      chk("big fwd_a mem", sb1.forward_ae, 2'b10);
      chk("big fwd_b mem", sb1.forward_be, 2'b10);
      #1 chk("big second read", sb1.stall_d, 0);
      tick();
      chk("big fwd_a wb", sb1.forward_ae, 2'b01);
      set1(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      chk("big drained", sb1.busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
